// File: rtl/conv_acc_pkg.sv
// Shared definitions for the psum collector: FSM states, width defaults and sign extension.
package conv_acc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAccWidth  = 32;

    // Sign-extend the low 'width' bits of val to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext_to64(input logic [63:0] val, input int unsigned width);
        logic [63:0] mask;
        logic        sign;
        mask = ~64'd0 << width;
        sign = |(val & (64'd1 << (width - 1)));
        return sign ? (val | mask) : (val & ~mask);
    endfunction

endpackage

// File: rtl/psum_acc_buf.sv
// Accumulation buffer: one packed row of NUM_COL accumulators per address.
// The write port has a same-address combinational read for read-modify-write,
// and a separate read port with registered data feeds the drain.
module psum_acc_buf #(
    parameter int unsigned NUM_COL   = 3,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_LEN   = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                         clk_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [NUM_COL*ACC_WIDTH-1:0] wr_data_i,
    output logic [NUM_COL*ACC_WIDTH-1:0] rmw_data_o,
    input  logic                         rd_en_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [NUM_COL*ACC_WIDTH-1:0] rd_data_o
);

    logic [NUM_COL*ACC_WIDTH-1:0] mem_q [OUT_LEN];
    logic [NUM_COL*ACC_WIDTH-1:0] rd_data_q;

    // Storage write; no reset because pass 0 of every job overwrites each used row.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value while rd_en_i is low (output stall).
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    // Same-cycle read of the row being updated keeps accumulation at one beat per cycle.
    assign rmw_data_o = mem_q[wr_addr_i];
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/psum_collector.sv
// Collects PE-array column psums, accumulates them over several passes and drains
// the results as a valid/ready stream.
module psum_collector
    import conv_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth,
    parameter int unsigned NUM_COL    = 3,
    parameter int unsigned OUT_LEN    = 16,
    parameter int unsigned LEN_W      = $clog2(OUT_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic [7:0]                    cfg_num_pass,
    input  logic                          psum_in_valid,
    output logic                          psum_in_ready,
    input  logic [NUM_COL*DATA_WIDTH-1:0] psum_in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_COL*ACC_WIDTH-1:0]  out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    // ACC_WIDTH is limited to 64 by the sign-extension helper.
    localparam int unsigned ADDR_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(OUT_LEN);

    state_e state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       num_pass_q, num_pass_d;
    logic [7:0]       pass_q, pass_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;

    logic             cfg_fire;
    logic             in_fire;
    logic             out_fire;
    logic             idx_wrap;
    logic             fetch;
    logic [LEN_W-1:0] len_last;

    logic [NUM_COL*ACC_WIDTH-1:0] wr_data;
    logic [NUM_COL*ACC_WIDTH-1:0] rmw_data;
    logic [NUM_COL*ACC_WIDTH-1:0] rd_data;

    // cfg_ready is gated by rst so it reads low while reset is held.
    assign cfg_ready     = (state_q == StIdle) && !rst;
    assign psum_in_ready = (state_q == StAccum);
    assign busy          = (state_q != StIdle);
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_data      = out_valid_q ? rd_data : '0;
    assign done          = done_q;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign in_fire  = psum_in_valid && psum_in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign len_last = len_q - 1'b1;
    assign idx_wrap = (idx_q == len_last);
    // Prefetch the next row whenever the output register is empty or being consumed.
    assign fetch    = (state_q == StDrain) && (rd_ptr_q < len_q) && (!out_valid_q || out_ready);

    // Per-column accumulate: pass 0 overwrites, later passes add with wrap-around.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        logic [DATA_WIDTH-1:0] col_in;
        logic [ACC_WIDTH-1:0]  col_ext;
        logic [ACC_WIDTH-1:0]  col_old;
        assign col_in  = psum_in_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign col_ext = ACC_WIDTH'(sext_to64(64'(col_in), DATA_WIDTH));
        assign col_old = rmw_data[c*ACC_WIDTH +: ACC_WIDTH];
        assign wr_data[c*ACC_WIDTH +: ACC_WIDTH] = (pass_q == 8'd0) ? col_ext
                                                                     : col_old + col_ext;
    end

    psum_acc_buf #(
        .NUM_COL  (NUM_COL),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_LEN  (OUT_LEN),
        .ADDR_W   (ADDR_W)
    ) u_buf (
        .clk_i     (clk),
        .wr_en_i   (in_fire),
        .wr_addr_i (ADDR_W'(idx_q)),
        .wr_data_i (wr_data),
        .rmw_data_o(rmw_data),
        .rd_en_i   (fetch),
        .rd_addr_i (ADDR_W'(rd_ptr_q)),
        .rd_data_o (rd_data)
    );

    // Next-state logic for the FSM, counters, latched config and output flags.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_pass_d  = num_pass_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    len_d      = ((cfg_len == '0) || (cfg_len > MaxLen)) ? MaxLen : cfg_len;
                    num_pass_d = (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
                    idx_d      = '0;
                    pass_d     = '0;
                    state_d    = StAccum;
                end
            end
            StAccum: begin
                if (in_fire) begin
                    if (idx_wrap) begin
                        idx_d  = '0;
                        pass_d = pass_q + 8'd1;
                        if (pass_q == num_pass_q - 8'd1) begin
                            state_d     = StDrain;
                            rd_ptr_d    = '0;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (fetch) begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_ptr_q == len_last);
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
                if (out_fire && out_last_q) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; reset discards any partial job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            num_pass_q  <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_pass_q  <= num_pass_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Randomized self-checking bench for psum_collector against a per-job arithmetic model.
module tb_psum_collector;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_len;
    logic [7:0]  cfg_num_pass;
    logic        psum_in_valid;
    logic        psum_in_ready;
    logic [47:0] psum_in_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    // Second instance with a 16-bit accumulator for the wrap-around case.
    logic        w_cfg_valid;
    logic        w_cfg_ready;
    logic [4:0]  w_cfg_len;
    logic [7:0]  w_cfg_num_pass;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [47:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [47:0] w_out_data;
    logic        w_out_last;
    logic        w_busy;
    logic        w_done;

    int n_tests = 0;
    int n_fail  = 0;

    int          L;
    int          P;
    int          feed_pos;
    logic [47:0] in_mem  [8][16];
    logic [31:0] exp_mem [16][3];

    psum_collector u_dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_len      (cfg_len),
        .cfg_num_pass (cfg_num_pass),
        .psum_in_valid(psum_in_valid),
        .psum_in_ready(psum_in_ready),
        .psum_in_data (psum_in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    psum_collector #(
        .DATA_WIDTH(16),
        .ACC_WIDTH (16)
    ) u_dut_w (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (w_cfg_valid),
        .cfg_ready    (w_cfg_ready),
        .cfg_len      (w_cfg_len),
        .cfg_num_pass (w_cfg_num_pass),
        .psum_in_valid(w_in_valid),
        .psum_in_ready(w_in_ready),
        .psum_in_data (w_in_data),
        .out_valid    (w_out_valid),
        .out_ready    (w_out_ready),
        .out_data     (w_out_data),
        .out_last     (w_out_last),
        .busy         (w_busy),
        .done         (w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build the input stream for P passes of L beats.
    task automatic gen(input int mode);
        for (int p = 0; p < P; p++) begin
            for (int k = 0; k < L; k++) begin
                case (mode)
                    0:       in_mem[p][k] = 48'({$urandom(), $urandom()});
                    1:       in_mem[p][k] = {16'(3 * k), 16'(2 * k), 16'(k)};
                    2:       in_mem[p][k] = {16'h7FFF, 16'h0007, 16'hFFFB};
                    default: in_mem[p][k] = {3{16'd9}};
                endcase
            end
        end
    endtask

    // Reference: signed sum over passes per beat and column, reduced modulo 2^32.
    task automatic compute_exp();
        logic [15:0] v;
        longint      s;
        for (int k = 0; k < L; k++) begin
            for (int c = 0; c < 3; c++) begin
                s = 0;
                for (int p = 0; p < P; p++) begin
                    v = 16'(in_mem[p][k] >> (16 * c));
                    s += longint'($signed(v));
                end
                exp_mem[k][c] = 32'(s);
            end
        end
    endtask

    function automatic logic [95:0] exp_vec(input int k);
        return {exp_mem[k][2], exp_mem[k][1], exp_mem[k][0]};
    endfunction

    task automatic do_cfg(input int len_raw, input int np_raw, input int mode);
        int cyc = 0;
        L = (len_raw == 0 || len_raw > 16) ? 16 : len_raw;
        P = (np_raw == 0) ? 1 : np_raw;
        gen(mode);
        compute_exp();
        while (!cfg_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("cfg_ready_wait", 128'(cfg_ready), 128'(1));
        cfg_valid    = 1'b1;
        cfg_len      = 5'(len_raw);
        cfg_num_pass = 8'(np_raw);
        @(negedge clk);
        cfg_valid = 1'b0;
        check_val("cfg_in_ready", 128'(psum_in_ready), 128'(1));
        check_val("cfg_busy", 128'(busy), 128'(1));
        check_val("cfg_not_ready", 128'(cfg_ready), 128'(0));
        feed_pos = 0;
    endtask

    // Feed n beats; returns at the falling edge after the last accepted beat.
    task automatic feed(input int n, input bit rnd_v, input bit inject);
        int cyc = 0;
        bit acc;
        while (feed_pos < n && cyc < 50 + 8 * n) begin
            psum_in_data  = in_mem[feed_pos / L][feed_pos % L];
            psum_in_valid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && cyc == 0) begin
                cfg_valid    = 1'b1;
                cfg_len      = 5'd1;
                cfg_num_pass = 8'd1;
            end
            check_val("in_ready", 128'(psum_in_ready), 128'(1));
            acc = psum_in_valid;
            @(posedge clk);
            if (acc) feed_pos++;
            @(negedge clk);
            cfg_valid     = 1'b0;
            psum_in_valid = 1'b0;
            cyc++;
        end
        if (feed_pos < n) check_val("feed_timeout", 128'(feed_pos), 128'(n));
    endtask

    task automatic drain(input bit stall, input bit rnd_r);
        int beat = 0;
        int cyc  = 0;
        bit stalled = 1'b0;
        check_val("lat_valid0", 128'(out_valid), 128'(0));
        check_val("lat_busy", 128'(busy), 128'(1));
        @(negedge clk);
        check_val("lat_valid1", 128'(out_valid), 128'(1));
        while (beat < L && cyc < 400) begin
            if (stall && beat == 1 && !stalled) begin
                out_ready = 1'b0;
                repeat (5) begin
                    check_val("stall_valid", 128'(out_valid), 128'(1));
                    check_val("stall_data", 128'(out_data), 128'(exp_vec(1)));
                    @(negedge clk);
                end
                stalled = 1'b1;
            end
            out_ready     = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
            psum_in_valid = 1'($urandom_range(0, 1));
            psum_in_data  = 48'({$urandom(), $urandom()});
            if (out_valid && out_ready) begin
                check_val("out_data", 128'(out_data), 128'(exp_vec(beat)));
                check_val("out_last", 128'(out_last), 128'(beat == L - 1));
                check_val("drain_in_ready", 128'(psum_in_ready), 128'(0));
                check_val("drain_done", 128'(done), 128'(0));
                beat++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready     = 1'b0;
        psum_in_valid = 1'b0;
        if (beat < L) begin
            check_val("drain_timeout", 128'(beat), 128'(L));
        end else begin
            check_val("done_pulse", 128'(done), 128'(1));
            check_val("end_cfg_ready", 128'(cfg_ready), 128'(1));
            check_val("end_busy", 128'(busy), 128'(0));
            check_val("end_valid", 128'(out_valid), 128'(0));
            @(negedge clk);
            check_val("done_clear", 128'(done), 128'(0));
        end
    endtask

    task automatic run_job(input int len_raw, input int np_raw, input int mode, input bit rnd_v,
                           input bit rnd_r, input bit stall, input bit inject);
        do_cfg(len_raw, np_raw, mode);
        feed(L * P, rnd_v, inject);
        drain(stall, rnd_r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cfg_ready"}, 128'(cfg_ready), 128'(0));
        check_val({tag, "_in_ready"}, 128'(psum_in_ready), 128'(0));
        check_val({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_val({tag, "_out_last"}, 128'(out_last), 128'(0));
        check_val({tag, "_out_data"}, 128'(out_data), 128'(0));
        check_val({tag, "_busy"}, 128'(busy), 128'(0));
        check_val({tag, "_done"}, 128'(done), 128'(0));
    endtask

    initial begin
        rst            = 1'b1;
        cfg_valid      = 1'b0;
        cfg_len        = '0;
        cfg_num_pass   = '0;
        psum_in_valid  = 1'b0;
        psum_in_data   = '0;
        out_ready      = 1'b0;
        w_cfg_valid    = 1'b0;
        w_cfg_len      = '0;
        w_cfg_num_pass = '0;
        w_in_valid     = 1'b0;
        w_in_data      = '0;
        w_out_ready    = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check_val("rst_release_cfg_ready", 128'(cfg_ready), 128'(1));
        @(negedge clk);

        // Single pass, ramp pattern.
        run_job(4, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Three passes with negative and large values.
        run_job(2, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        // Output stall mid-drain with random input valid.
        run_job(5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        // Clamped config plus an ignored cfg pulse during accumulation.
        run_job(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_job(20, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of pass 1.
        do_cfg(4, 2, 0);
        feed(7, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_release", 128'(cfg_ready), 128'(1));
        @(negedge clk);
        run_job(2, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 0, 1'b1, 1'b1,
                    1'($urandom_range(0, 1)), 1'b0);
        end

        // Wrap-around on the 16-bit accumulator instance.
        w_cfg_valid    = 1'b1;
        w_cfg_len      = 5'd1;
        w_cfg_num_pass = 8'd2;
        @(negedge clk);
        w_cfg_valid = 1'b0;
        w_in_valid  = 1'b1;
        w_in_data   = {3{16'h7FFF}};
        repeat (2) @(negedge clk);
        w_in_valid = 1'b0;
        for (int i = 0; i < 10 && !w_out_valid; i++) @(negedge clk);
        check_val("wrap_valid", 128'(w_out_valid), 128'(1));
        check_val("wrap_data", 128'(w_out_data), 128'({3{16'hFFFE}}));
        check_val("wrap_last", 128'(w_out_last), 128'(1));
        @(negedge clk);
        check_val("wrap_done", 128'(w_done), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
